// File: rtl/bn_stream_ctrl.sv
// Batch sequencer between a sample stream and a BN2d engine: buffers LEN inputs,
// issues them to the engine, collects LEN results and streams them back out.
module bn_stream_ctrl #(
  parameter int LEN = 5,
  parameter int AW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] weight_in,
  input  logic signed [15:0] bias_in,
  input  logic               in_valid,
  input  logic signed [15:0] in_data,
  output logic               in_ready,
  output logic signed [15:0] bn_data,
  output logic signed [15:0] bn_weight,
  output logic signed [15:0] bn_bias,
  input  logic signed [15:0] bn_result,
  input  logic               bn_finish,
  output logic               out_valid,
  output logic signed [15:0] out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int            IW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_OUT} state_t;

  state_t                state_q,   state_d;
  logic [AW-1:0]         wr_idx_q,  wr_idx_d;
  logic [AW-1:0]         iss_idx_q, iss_idx_d;
  logic [AW-1:0]         res_idx_q, res_idx_d;
  logic [AW-1:0]         rd_idx_q,  rd_idx_d;
  logic signed [15:0]    weight_q,  weight_d;
  logic signed [15:0]    bias_q,    bias_d;
  logic                  done_q,    done_d;
  logic signed [15:0]    inbuf_q  [LEN];
  logic signed [15:0]    inbuf_d  [LEN];
  logic signed [15:0]    outbuf_q [LEN];
  logic signed [15:0]    outbuf_d [LEN];

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    iss_idx_d = iss_idx_q;
    res_idx_d = res_idx_q;
    rd_idx_d  = rd_idx_q;
    weight_d  = weight_q;
    bias_d    = bias_q;
    done_d    = 1'b0;
    inbuf_d   = inbuf_q;
    outbuf_d  = outbuf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          weight_d  = weight_in;
          bias_d    = bias_in;
          wr_idx_d  = '0;
          iss_idx_d = '0;
          res_idx_d = '0;
          rd_idx_d  = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          inbuf_d[wr_idx_q[IW-1:0]] = in_data;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // issue pointer parks on the last element; the engine may keep sampling it
        if (iss_idx_q != LAST) iss_idx_d = iss_idx_q + 1'b1;
        if (bn_finish) begin
          outbuf_d[res_idx_q[IW-1:0]] = bn_result;
          res_idx_d = res_idx_q + 1'b1;
          if (res_idx_q == LAST) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_idx_q  <= '0;
      iss_idx_q <= '0;
      res_idx_q <= '0;
      rd_idx_q  <= '0;
      weight_q  <= '0;
      bias_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      iss_idx_q <= iss_idx_d;
      res_idx_q <= res_idx_d;
      rd_idx_q  <= rd_idx_d;
      weight_q  <= weight_d;
      bias_q    <= bias_d;
      done_q    <= done_d;
    end
  end

  // Sample storage carries no reset; every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    inbuf_q  <= inbuf_d;
    outbuf_q <= outbuf_d;
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign bn_weight = weight_q;
  assign bn_bias   = bias_q;
  assign bn_data   = (state_q == S_RUN) ? inbuf_q[iss_idx_q[IW-1:0]] : '0;
  assign out_data  = (state_q == S_OUT) ? outbuf_q[rd_idx_q[IW-1:0]] : '0;

endmodule

// File: tb/tb_bn_stream_ctrl.sv
// Directed bench for bn_stream_ctrl with a BN engine stub that echoes bn_data.
module tb_bn_stream_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] weight_in = '0;
  logic signed [15:0] bias_in = '0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_ready;
  logic signed [15:0] bn_data;
  logic signed [15:0] bn_weight;
  logic signed [15:0] bn_bias;
  logic signed [15:0] bn_result;
  logic               bn_finish;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_ready = 1'b1;
  logic               busy;
  logic               done;

  bn_stream_ctrl #(.LEN(5), .AW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .weight_in(weight_in), .bias_in(bias_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bn_data(bn_data), .bn_weight(bn_weight), .bn_bias(bn_bias),
    .bn_result(bn_result), .bn_finish(bn_finish),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Engine stub. mode 0: echo with 2-cycle latency. mode 1: 7-cycle finish burst, zero latency.
  int                 mode = 0;
  int                 rcyc = 0;
  logic [1:0]         vpipe = 2'b00;
  logic signed [15:0] dp0 = '0, dp1 = '0;
  logic               run_now;
  assign run_now = busy && !in_ready && !out_valid;

  always @(posedge clk) begin
    vpipe <= {vpipe[0], run_now};
    dp0   <= bn_data;
    dp1   <= dp0;
    if (run_now || (rcyc != 0 && rcyc < 7)) rcyc <= rcyc + 1;
    else rcyc <= 0;
  end

  always_comb begin
    bn_finish = vpipe[1];
    bn_result = dp1;
    if (mode == 1) begin
      bn_finish = run_now || (rcyc != 0 && rcyc < 7);
      bn_result = bn_data;
    end
  end

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_batch(input logic signed [15:0] w, input logic signed [15:0] b);
    start = 1'b1; weight_in = w; bias_in = b;
    step();
    start = 1'b0; weight_in = 16'sd0; bias_in = 16'sd0;
  endtask

  task automatic load(input logic signed [15:0] v [5], input bit gaps);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = v[i];
      step();
      if (gaps && i < 4) begin
        in_valid = 1'b0; in_data = 16'sh5A5A;
        @(negedge clk);
        chk("load_gap_ready", 16'(in_ready), 16'd1);
        step();
      end
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  // Drains one batch; pat gives out_ready per OUT cycle, cycling.
  task automatic drain(input logic signed [15:0] v [5], input logic [3:0] pat);
    int idx = 0, pidx = 0, cyc = 0;
    while (idx < 5 && cyc < 60) begin
      out_ready = pat[pidx % 4];
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("out_data[%0d]", idx), out_data, v[idx]);
        chk("bn_data_in_out", bn_data, 16'd0);
        if (out_ready) idx++;
        pidx++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b1;
    chk("drain_count", 16'(idx), 16'd5);
    @(negedge clk);
    chk("done_pulse", 16'(done), 16'd1);
    chk("busy_after", 16'(busy), 16'd0);
    chk("out_valid_after", 16'(out_valid), 16'd0);
    step();
    @(negedge clk);
    chk("done_once", 16'(done), 16'd0);
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"},  16'(in_ready),  16'd0);
    chk({tag, "_out_valid"}, 16'(out_valid), 16'd0);
    chk({tag, "_out_data"},  out_data,       16'd0);
    chk({tag, "_bn_data"},   bn_data,        16'd0);
    chk({tag, "_bn_weight"}, bn_weight,      16'd0);
    chk({tag, "_bn_bias"},   bn_bias,        16'd0);
    chk({tag, "_busy"},      16'(busy),      16'd0);
    chk({tag, "_done"},      16'(done),      16'd0);
  endtask

  logic signed [15:0] va [5] = '{16'sd100, -16'sd200, 16'sd300, 16'sh7FFF, 16'sh8000};
  logic signed [15:0] vb [5] = '{16'sd1, 16'sd2, -16'sd3, 16'sd4, -16'sd5};
  logic signed [15:0] vc [5] = '{16'sd11, 16'sd22, 16'sd33, 16'sd44, 16'sd55};
  logic signed [15:0] vd [5] = '{16'sd7, 16'sd8, 16'sd9, 16'sd10, 16'sd11};

  initial begin
    // reset with start held high: reset wins
    start = 1'b1; weight_in = 16'sd99;
    step(); step();
    rst = 1'b0; start = 1'b0; weight_in = '0;
    chk_reset_outputs("reset");

    // nominal batch
    start_batch(16'sd2540, 16'sd8422);
    @(negedge clk);
    chk("load_busy", 16'(busy), 16'd1);
    chk("load_ready", 16'(in_ready), 16'd1);
    chk("bn_weight", bn_weight, 16'd2540);
    chk("bn_bias", bn_bias, 16'd8422);
    step();
    load(va, 1'b0);
    @(negedge clk);
    chk("run_ready", 16'(in_ready), 16'd0);
    chk("run_busy", 16'(busy), 16'd1);
    chk("run_bn_data0", bn_data, 16'd100);
    step();
    drain(va, 4'b1111);
    chk("bn_weight_hold", bn_weight, 16'd2540);

    // input gaps, start-while-busy, backpressure 1,0,0,1
    start_batch(16'sd2540, 16'sd8422);
    load(vb, 1'b1);
    @(negedge clk);
    chk("gap_run_ready", 16'(in_ready), 16'd0);
    chk("gap_run_busy", 16'(busy), 16'd1);
    chk("gap_bn_data0", bn_data, 16'd1);
    start = 1'b1; weight_in = 16'sd1; bias_in = 16'sd1;
    in_valid = 1'b1; in_data = 16'sh1234;
    step();
    start = 1'b0; weight_in = '0; bias_in = '0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    chk("busy_start_weight", bn_weight, 16'd2540);
    chk("busy_start_bias", bn_bias, 16'd8422);
    chk("busy_start_bn_data1", bn_data, 16'd2);
    step();
    drain(vb, 4'b1001);

    // extra finish pulses
    mode = 1;
    start_batch(16'sd2540, 16'sd8422);
    load(vc, 1'b0);
    drain(vc, 4'b1111);
    mode = 0;

    // mid-run reset on the 3rd RUN cycle
    start_batch(16'sd2540, 16'sd8422);
    load(va, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    in_valid = 1'b1; in_data = 16'sh7777;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    chk("midrst_idle_busy", 16'(busy), 16'd0);
    chk("midrst_idle_valid", 16'(out_valid), 16'd0);
    step();

    // follow-up batch after reset
    start_batch(-16'sd1234, 16'sd555);
    @(negedge clk);
    chk("post_weight", bn_weight, 16'hFB2E);
    chk("post_bias", bn_bias, 16'd555);
    step();
    load(vd, 1'b0);
    drain(vd, 4'b1011);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
